// File: rtl/dmem_store_responder.sv
// Memory-side responder for the core's store port: word-addressed data RAM with a
// combinational read, plus a sticky PASS/FAIL/TIMEOUT verdict exposed as status outputs.
module dmem_store_responder #(
    parameter int    DEPTH       = 64,
    parameter string INIT_FILE   = "",
    parameter int    SIG_ADR     = 100,
    parameter int    SIG_DATA    = 25,
    parameter int    SCRATCH_ADR = 96,
    parameter int    TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [15:0] store_count,
    output logic [31:0] last_adr,
    output logic [31:0] last_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_ADDR    = 2'b10,
        FC_TIMEOUT = 2'b11
    } fail_e;

    logic [31:0]   r_mem [DEPTH];
    state_e        r_state;
    fail_e         r_fail_code;
    logic          r_done;
    logic          r_pass;
    logic [15:0]   r_store_count;
    logic [31:0]   r_last_adr;
    logic [31:0]   r_last_data;
    logic [CW-1:0] r_cyc;

    logic          w_in_range;
    logic          w_legal;
    logic          w_is_sig;
    logic          w_is_scratch;
    logic          w_sig_data_ok;
    logic [AW-1:0] w_idx;
    logic [CW-1:0] w_cyc_next;

    assign w_in_range    = (DataAdr < 32'(DEPTH * 4));
    assign w_legal       = w_in_range && (DataAdr[1:0] == 2'b00);
    assign w_is_sig      = (DataAdr == 32'(SIG_ADR));
    assign w_is_scratch  = (DataAdr == 32'(SCRATCH_ADR));
    assign w_sig_data_ok = (WriteData == 32'(SIG_DATA));
    assign w_idx         = DataAdr[AW+1:2];
    assign w_cyc_next    = r_cyc + CW'(1);

    // NOTE: the RAM has no reset on purpose -- memory must survive a mid-run reset,
    // and a reset branch would also stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (MemWrite && w_legal) r_mem[w_idx] <= WriteData;
    end

    // Read-before-write: a store becomes visible on the following cycle.
    assign ReadData = w_in_range ? r_mem[w_idx] : 32'h0;

    // NOTE: non-blocking assignments throughout so every register samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_fail_code   <= FC_NONE;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_store_count <= 16'h0;
            r_last_adr    <= 32'h0;
            r_last_data   <= 32'h0;
            r_cyc         <= '0;
        end else begin
            // Capture runs in every state; an X strobe falls to the else path here.
            if (MemWrite) begin
                r_last_adr  <= DataAdr;
                r_last_data <= WriteData;
                if (r_store_count != 16'hFFFF) r_store_count <= r_store_count + 16'h1;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                    r_cyc   <= '0;
                end
                S_RUN: begin
                    // Store verdicts outrank the timeout; scratch stores fall through.
                    if (MemWrite && !w_legal) begin
                        r_state     <= S_FAIL;
                        r_done      <= 1'b1;
                        r_fail_code <= FC_ADDR;
                    end else if (MemWrite && w_is_sig && w_sig_data_ok) begin
                        r_state <= S_PASS;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                    end else if (MemWrite && !w_is_scratch) begin
                        r_state     <= S_FAIL;
                        r_done      <= 1'b1;
                        r_fail_code <= FC_ILLEGAL;
                    end else if (w_cyc_next == CW'(TIMEOUT - 1)) begin
                        r_state     <= S_TIMEOUT;
                        r_done      <= 1'b1;
                        r_fail_code <= FC_TIMEOUT;
                    end else begin
                        r_cyc <= w_cyc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_fail_code;
    assign store_count = r_store_count;
    assign last_adr    = r_last_adr;
    assign last_data   = r_last_data;

endmodule
